// File: rtl/dma_defs.sv
// rtl/dma_defs.sv - shared state encodings, bus select codes and default addresses for the DMA arbiter
package dma_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  typedef enum logic [1:0] {
    SEL_CPU    = 2'd0,
    SEL_DMA_RD = 2'd1,
    SEL_DMA_WR = 2'd2
  } bus_sel_e;

  localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] DEF_DEST_ADDR = 16'h2004;

endpackage

// File: rtl/dma_bus_mux.sv
// rtl/dma_bus_mux.sv - combinational select of the external bus between CPU, DMA read and DMA write
module dma_bus_mux
  import dma_defs::*;
(
  input  bus_sel_e    sel_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_odata_i,
  input  logic        cpu_rw_i,
  input  logic [15:0] rd_addr_i,
  input  logic [15:0] wr_addr_i,
  input  logic [7:0]  dma_odata_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_odata_o,
  output logic        bus_rw_o
);

  always_comb begin
    bus_addr_o  = cpu_addr_i;
    bus_odata_o = cpu_odata_i;
    bus_rw_o    = cpu_rw_i;
    case (sel_i)
      SEL_DMA_RD: begin
        bus_addr_o  = rd_addr_i;
        bus_odata_o = dma_odata_i;
        bus_rw_o    = 1'b1;
      end
      SEL_DMA_WR: begin
        bus_addr_o  = wr_addr_i;
        bus_odata_o = dma_odata_i;
        bus_rw_o    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - halts the 6502 and copies one 256-byte page to a fixed port on a trigger store
module dma_bus_arbiter
  import dma_defs::*;
#(
  parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
  parameter logic [15:0] DEST_ADDR = DEF_DEST_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_stb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_idata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic       parity_q;
  bus_sel_e   sel;
  logic [15:0] rd_addr;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (cyc_stb) begin
      case (state_q)
        IDLE: begin
          if (!cpu_rw && cpu_addr == TRIG_ADDR) begin
            page_d  = cpu_odata;
            idx_d   = 8'h00;
            state_d = HALT;
          end
        end
        // the 6502 only honours rdy on a read, so pending writes must drain first
        HALT:  if (cpu_rw) state_d = ALIGN;
        ALIGN: if (parity_q) state_d = READ;
        READ: begin
          buf_d   = mem_idata;
          state_d = WRITE;
        end
        WRITE: begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? IDLE : READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      buf_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      parity_q <= parity_q ^ cyc_stb;
    end
  end

  // ALIGN reuses the read path but keeps the CPU's address as a harmless dummy read
  always_comb begin
    sel     = SEL_CPU;
    rd_addr = {page_q, idx_q};
    case (state_q)
      ALIGN: begin
        sel     = SEL_DMA_RD;
        rd_addr = cpu_addr;
      end
      READ:    sel = SEL_DMA_RD;
      WRITE:   sel = SEL_DMA_WR;
      default: sel = SEL_CPU;
    endcase
  end

  assign cpu_rdy    = (state_q == IDLE);
  assign dma_active = (state_q == ALIGN) || (state_q == READ) || (state_q == WRITE);

  dma_bus_mux u_mux (
    .sel_i       (sel),
    .cpu_addr_i  (cpu_addr),
    .cpu_odata_i (cpu_odata),
    .cpu_rw_i    (cpu_rw),
    .rd_addr_i   (rd_addr),
    .wr_addr_i   (DEST_ADDR),
    .dma_odata_i (buf_q),
    .bus_addr_o  (bus_addr),
    .bus_odata_o (bus_odata),
    .bus_rw_o    (bus_rw)
  );

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the single cpu6502 external bus between the CPU and a page-copy DMA engine.
- A CPU store to TRIG_ADDR starts a 256-byte transfer: source is page {data,8'h00}, destination is the fixed port DEST_ADDR.
- While the DMA runs, the block halts the CPU via cpu_rdy and drives the memory bus itself; otherwise it passes CPU signals straight through.
- Sits between cpu6502 and the rom/ram/peripheral decode.

Parameters:
TRIG_ADDR, 16'h4014, CPU write address that triggers DMA (written byte = source page)
DEST_ADDR, 16'h2004, fixed destination address for every DMA write

Ports:
clk  in  1  system clock, same clk as cpu6502
reset  in  1  asynchronous, active-high reset
cyc_stb  in  1  one-clk pulse marking the end of each CPU bus cycle (falling edge of clk2, detected externally)
cpu_addr  in  16  CPU address
cpu_odata  in  8  CPU write data
cpu_rw  in  1  CPU read(1)/write(0)
mem_idata  in  8  read data returned from memory decode
bus_addr  out  16  address to memory decode
bus_odata  out  8  write data to memory decode
bus_rw  out  1  read(1)/write(0) to memory decode
cpu_rdy  out  1  1 = CPU may proceed; 0 = CPU halts on its current read cycle
dma_active  out  1  1 while the DMA owns the bus (ALIGN/READ/WRITE)

Behaviour:
- States: IDLE, HALT, ALIGN, READ, WRITE. All transitions occur only on clk edges where cyc_stb=1; otherwise the state holds.
- Reset (async): state=IDLE, page=0, idx=0, buf=0, parity=0, cpu_rdy=1, dma_active=0. Bus is in pass-through.
- parity toggles on every cyc_stb in all states. It is cleared only by reset.
- Pass-through (IDLE, HALT): bus_addr=cpu_addr, bus_odata=cpu_odata, bus_rw=cpu_rw. Purely combinational, zero latency.
- IDLE: on cyc_stb with cpu_rw=0 and cpu_addr==TRIG_ADDR:
  - page<=cpu_odata, idx<=0, go to HALT.
  - The triggering store itself completes normally on the bus.
- HALT: cpu_rdy=0. The CPU may still finish writes; the 6502 halts only on a read.
  - On cyc_stb with cpu_rw=1, go to ALIGN.
  - On cyc_stb with cpu_rw=0, stay in HALT.
- ALIGN: dma_active=1, bus_rw=1, bus_addr=cpu_addr (dummy read; result discarded).
  - On cyc_stb: if parity==1 (odd cycle), go to READ; else stay in ALIGN one more cycle.
  - Net effect: one or two dummy cycles, so READ always starts on an even cycle.
- READ: bus_addr={page,idx}, bus_rw=1, bus_odata=buf.
  - On cyc_stb: buf<=mem_idata, go to WRITE.
- WRITE: bus_addr=DEST_ADDR, bus_odata=buf, bus_rw=0.
  - On cyc_stb: idx<=idx+1 (8-bit wrap).
  - If idx==8'hFF, go to IDLE. cpu_rdy returns to 1 combinationally from state, so the CPU resumes on the next bus cycle.
  - Otherwise go to READ.
- cpu_rdy=0 in HALT/ALIGN/READ/WRITE; dma_active=1 in ALIGN/READ/WRITE.
- Total CPU stall from the end of the trigger cycle: HALT cycles + (1 or 2) + 512.
- Page wrap: source address never carries into the high byte; idx FF→00 terminates the transfer.
- page=8'hFF is legal: source range is FF00–FFFF.
- A write to TRIG_ADDR while not IDLE is ignored; page is not reloaded. The CPU is halted then anyway.
- A trigger and a cyc_stb arriving together with reset: reset wins.
- Reset mid-transfer: immediate return to IDLE with pass-through. Partial data already written stays written.
- Outputs in IDLE are combinational pass-through. State, page, idx, buf and parity are registered.

Decomposition:
- Shared package/header `dma_defs`:
  - state encodings (IDLE=0, HALT=1, ALIGN=2, READ=3, WRITE=4)
  - default TRIG_ADDR and DEST_ADDR constants
- One natural sub-module, `dma_bus_mux`: combinational 3-way select of addr/odata/rw (cpu, dma-read, dma-write) keyed by state. The top module holds the FSM, counters and buffer.

Test Plan:
- Reset held 4 clks, then released with CPU running LDA/STA from ROM -> cpu_rdy=1, dma_active=0, bus_addr tracks cpu_addr every clk.
- CPU executes LDA #$02; STA $4014 -> page=8'h02, next cyc_stb HALT. First READ bus_addr=16'h0200, first WRITE bus_addr=16'h2004 with bus_odata=mem[16'h0200], bus_rw=0.
- Full transfer from page 2 with mem[0x0200+i]=i -> 256 writes to 16'h2004 carrying 0x00..0xFF in order. cpu_rdy returns 1 after exactly 512 + (1 or 2) + HALT cycles; count the cyc_stb pulses.
- Trigger on an even vs odd parity cycle -> ALIGN lasts 2 vs 1 cycles, and READ always begins with parity==0.
- Trigger when the CPU's next cycle is a write (e.g. STA $4014 followed by a push/RMW write) -> HALT persists through the write cycles. ALIGN starts only after the first cpu_rw=1 cycle.
- Source page 8'hFF, and a second STA $4014 injected mid-DMA -> last read at 16'hFFFF, no carry to 16'h0000, page unchanged. Reset asserted at transfer 100 -> next clk cpu_rdy=1, dma_active=0, pass-through restored.
